eth_mac_stats_counter: RTL and testbench



---
 rtl/eth_mac_stats_counter.sv | 125 ++++++++++++
 tb/tb_eth_mac_stats_counter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mac_stats_counter.sv
// Per-channel event/byte statistics counters with sticky overflow flags and a
// valid/ready read port returning one counter per request, optionally clearing it.
module eth_mac_stats_counter #(
  parameter int unsigned CHANNELS      = 8,
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned INC_WIDTH     = 1,
  parameter int unsigned SATURATE      = 1,
  parameter int unsigned CLEAR_ON_READ = 1,
  parameter int unsigned ADDR_WIDTH    = 8
) (
  input  logic                              logic_clk,
  input  logic                              logic_rst_n,
  input  logic                              enable,
  input  logic                              clear_all,
  input  logic [CHANNELS-1:0]               event_valid,
  input  logic [CHANNELS*INC_WIDTH-1:0]     event_inc,
  input  logic                              rd_req_valid,
  output logic                              rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]             rd_req_addr,
  output logic                              rd_resp_valid,
  input  logic                              rd_resp_ready,
  output logic [COUNT_WIDTH-1:0]            rd_resp_data,
  output logic                              rd_resp_overflow,
  output logic                              rd_resp_error
);

  localparam int unsigned SUM_W = COUNT_WIDTH + 1;

  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  cnt_t                cnt_q [CHANNELS];
  cnt_t                cnt_d [CHANNELS];
  logic [SUM_W-1:0]    sum_c [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;
  logic [CHANNELS-1:0] rd_hit_c;
  logic                accept_c;
  logic                addr_ok_c;
  cnt_t                sel_data_c;
  logic                sel_ovf_c;
  logic                resp_valid_d;
  cnt_t                resp_data_d;
  logic                resp_ovf_d;
  logic                resp_err_d;

  // One-deep response register: a new request fits whenever the slot drains this cycle.
  assign rd_req_ready = !rd_resp_valid || rd_resp_ready;

  // Counter update, read selection and response next-state.
  always_comb begin
    accept_c     = rd_req_valid && rd_req_ready;
    addr_ok_c    = 1'b0;
    sel_data_c   = '0;
    sel_ovf_c    = 1'b0;
    resp_valid_d = rd_resp_valid;
    resp_data_d  = rd_resp_data;
    resp_ovf_d   = rd_resp_overflow;
    resp_err_d   = rd_resp_error;

    for (int i = 0; i < int'(CHANNELS); i++) begin
      rd_hit_c[i] = (rd_req_addr == ADDR_WIDTH'(i));
      if (rd_hit_c[i]) begin
        addr_ok_c  = 1'b1;
        sel_data_c = cnt_q[i];
        sel_ovf_c  = ovf_q[i];
      end

      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      // Clear-on-read restarts from zero so the same-cycle increment is kept.
      if (accept_c && rd_hit_c[i] && (CLEAR_ON_READ != 0)) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end

      sum_c[i] = {1'b0, cnt_d[i]} + SUM_W'(event_inc[i*INC_WIDTH +: INC_WIDTH]);
      if (enable && event_valid[i]) begin
        if (sum_c[i][COUNT_WIDTH]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? '1 : sum_c[i][COUNT_WIDTH-1:0];
        end else begin
          cnt_d[i] = sum_c[i][COUNT_WIDTH-1:0];
        end
      end

      if (clear_all) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end
    end

    if (accept_c) begin
      resp_valid_d = 1'b1;
      resp_data_d  = sel_data_c;
      resp_ovf_d   = sel_ovf_c;
      resp_err_d   = !addr_ok_c;
    end else if (rd_resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q            <= '0;
      rd_resp_valid    <= 1'b0;
      rd_resp_data     <= '0;
      rd_resp_overflow <= 1'b0;
      rd_resp_error    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q            <= ovf_d;
      rd_resp_valid    <= resp_valid_d;
      rd_resp_data     <= resp_data_d;
      rd_resp_overflow <= resp_ovf_d;
      rd_resp_error    <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_eth_mac_stats_counter.sv
// Bench for eth_mac_stats_counter: a default 32-bit instance plus two 8-bit byte
// counters (saturating and wrapping), checked against a per-channel arithmetic model.
module tb_eth_mac_stats_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr;
  logic [7:0]  ev_valid, ev_inc;
  logic        rq_valid, rq_ready, rs_ready, rs_valid, rs_ovf, rs_err;
  logic [7:0]  rq_addr;
  logic [31:0] rs_data;

  logic [2:0]  n_ev_valid;
  logic [23:0] n_ev_inc;
  logic        n_rq_valid, n_rs_ready;
  logic [1:0]  n_rq_addr;
  logic        s_rq_ready, s_valid, s_ovf, s_err;
  logic        w_rq_ready, w_valid, w_ovf, w_err;
  logic [7:0]  s_data, w_data;

  int total = 0;
  int bad   = 0;

  longint unsigned m_cnt [3][8];
  bit              m_ovf [3][8];
  bit              m_rv  [3];
  longint unsigned m_rd  [3];
  bit              m_ro  [3];
  bit              m_re  [3];

  always #5 clk = ~clk;

  eth_mac_stats_counter dut (
    .logic_clk(clk), .logic_rst_n(rst_n), .enable(en), .clear_all(clr),
    .event_valid(ev_valid), .event_inc(ev_inc),
    .rd_req_valid(rq_valid), .rd_req_ready(rq_ready), .rd_req_addr(rq_addr),
    .rd_resp_valid(rs_valid), .rd_resp_ready(rs_ready), .rd_resp_data(rs_data),
    .rd_resp_overflow(rs_ovf), .rd_resp_error(rs_err)
  );

  eth_mac_stats_counter #(.CHANNELS(3), .COUNT_WIDTH(8), .INC_WIDTH(8), .SATURATE(1),
                          .CLEAR_ON_READ(1), .ADDR_WIDTH(2)) dut_sat (
    .logic_clk(clk), .logic_rst_n(rst_n), .enable(en), .clear_all(clr),
    .event_valid(n_ev_valid), .event_inc(n_ev_inc),
    .rd_req_valid(n_rq_valid), .rd_req_ready(s_rq_ready), .rd_req_addr(n_rq_addr),
    .rd_resp_valid(s_valid), .rd_resp_ready(n_rs_ready), .rd_resp_data(s_data),
    .rd_resp_overflow(s_ovf), .rd_resp_error(s_err)
  );

  eth_mac_stats_counter #(.CHANNELS(3), .COUNT_WIDTH(8), .INC_WIDTH(8), .SATURATE(0),
                          .CLEAR_ON_READ(1), .ADDR_WIDTH(2)) dut_wrap (
    .logic_clk(clk), .logic_rst_n(rst_n), .enable(en), .clear_all(clr),
    .event_valid(n_ev_valid), .event_inc(n_ev_inc),
    .rd_req_valid(n_rq_valid), .rd_req_ready(w_rq_ready), .rd_req_addr(n_rq_addr),
    .rd_resp_valid(w_valid), .rd_resp_ready(n_rs_ready), .rd_resp_data(w_data),
    .rd_resp_overflow(w_ovf), .rd_resp_error(w_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 8; c++) begin
        m_cnt[d][c] = 0;
        m_ovf[d][c] = 1'b0;
      end
      m_rv[d] = 1'b0; m_rd[d] = 0; m_ro[d] = 1'b0; m_re[d] = 1'b0;
    end
  endtask

  // What one rising edge does to each instance, from the inputs currently applied.
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int n;
      int a;
      bit v, rr, acc;
      longint unsigned mx, inc, sum;
      n  = (d == 0) ? 8 : 3;
      mx = (d == 0) ? 64'hFFFF_FFFF : 64'd255;
      v  = (d == 0) ? rq_valid : n_rq_valid;
      a  = (d == 0) ? int'(rq_addr) : int'(n_rq_addr);
      rr = (d == 0) ? rs_ready : n_rs_ready;
      acc = v && (!m_rv[d] || rr);
      if (acc) begin
        m_rv[d] = 1'b1;
        if (a < n) begin
          m_rd[d] = m_cnt[d][a]; m_ro[d] = m_ovf[d][a]; m_re[d] = 1'b0;
        end else begin
          m_rd[d] = 0; m_ro[d] = 1'b0; m_re[d] = 1'b1;
        end
      end else if (rr) begin
        m_rv[d] = 1'b0;
      end
      for (int c = 0; c < n; c++) begin
        if (clr) begin
          m_cnt[d][c] = 0; m_ovf[d][c] = 1'b0;
        end else begin
          if (acc && a == c) begin
            m_cnt[d][c] = 0; m_ovf[d][c] = 1'b0;
          end
          if (en && ((d == 0) ? ev_valid[c] : n_ev_valid[c])) begin
            inc = (d == 0) ? longint'(ev_inc[c]) : longint'(n_ev_inc[c*8 +: 8]);
            sum = m_cnt[d][c] + inc;
            if (sum > mx) begin
              m_ovf[d][c] = 1'b1;
              m_cnt[d][c] = (d == 2) ? sum - (mx + 1) : mx;
            end else begin
              m_cnt[d][c] = sum;
            end
          end
        end
      end
    end
  endtask

  // One clock: check ready before the edge, advance the model, check the response after.
  task automatic tick();
    #1;
    chk("req_ready", rq_ready, !m_rv[0] || rs_ready);
    chk("req_ready_sat", s_rq_ready, !m_rv[1] || n_rs_ready);
    chk("req_ready_wrap", w_rq_ready, !m_rv[2] || n_rs_ready);
    @(posedge clk);
    model_edge();
    #1;
    chk("resp_valid", rs_valid, m_rv[0]);
    if (m_rv[0]) begin
      chk("resp_data", rs_data, m_rd[0]);
      chk("resp_ovf", rs_ovf, m_ro[0]);
      chk("resp_err", rs_err, m_re[0]);
    end
    chk("resp_valid_sat", s_valid, m_rv[1]);
    if (m_rv[1]) begin
      chk("resp_data_sat", s_data, m_rd[1]);
      chk("resp_ovf_sat", s_ovf, m_ro[1]);
    end
    chk("resp_valid_wrap", w_valid, m_rv[2]);
    if (m_rv[2]) begin
      chk("resp_data_wrap", w_data, m_rd[2]);
      chk("resp_ovf_wrap", w_ovf, m_ro[2]);
    end
  endtask

  task automatic idle();
    en = 1'b1; clr = 1'b0; ev_valid = '0; ev_inc = '1;
    rq_valid = 1'b0; rq_addr = '0; rs_ready = 1'b1;
    n_ev_valid = '0; n_ev_inc = '0; n_rq_valid = 1'b0; n_rq_addr = '0; n_rs_ready = 1'b1;
  endtask

  task automatic rd0(input logic [7:0] addr);
    rq_valid = 1'b1; rq_addr = addr; rs_ready = 1'b1;
    tick();
    rq_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0;
    idle();
    model_reset();
    #2;
    chk("rst_valid", rs_valid, 1'b0);
    chk("rst_data", rs_data, 32'd0);
    chk("rst_ovf", rs_ovf, 1'b0);
    chk("rst_err", rs_err, 1'b0);
    chk("rst_ready", rq_ready, 1'b1);
    chk("rst_valid_sat", s_valid, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Five strobes on ch2, then read twice.
    ev_valid = 8'b0000_0100;
    repeat (5) tick();
    ev_valid = '0;
    rd0(8'd2);
    chk("ch2_five", rs_data, 32'd5);
    chk("ch2_five_ovf", rs_ovf, 1'b0);
    chk("ch2_five_err", rs_err, 1'b0);
    rd0(8'd2);
    chk("ch2_reread", rs_data, 32'd0);

    // Read ch1 in the same cycle it strobes.
    ev_valid = 8'b0000_0010;
    repeat (2) tick();
    rd0(8'd1);
    chk("ch1_old", rs_data, 32'd2);
    ev_valid = '0;
    rd0(8'd1);
    chk("ch1_kept_inc", rs_data, 32'd1);

    // 200 + 100 on 8-bit byte counters.
    n_ev_valid = 3'b001; n_ev_inc = 24'd200; tick();
    n_ev_inc = 24'd100; tick();
    n_ev_valid = '0; n_rq_valid = 1'b1; n_rq_addr = 2'd0;
    tick();
    n_rq_valid = 1'b0;
    chk("sat_255", s_data, 8'd255);
    chk("sat_ovf", s_ovf, 1'b1);
    chk("wrap_44", w_data, 8'd44);
    chk("wrap_ovf", w_ovf, 1'b1);
    tick();

    // Backpressure: response stalls, then back-to-back reads.
    ev_valid = 8'b0011_1000; tick(); tick(); ev_valid = '0;
    rs_ready = 1'b0; rq_valid = 1'b1; rq_addr = 8'd3;
    tick();
    held = rs_data;
    chk("stall_first", rs_data, 32'd2);
    repeat (3) begin
      rq_addr = 8'd4;
      tick();
      chk("stall_stable", rs_data, held);
      chk("stall_no_ready", rq_ready, 1'b0);
    end
    rs_ready = 1'b1;
    for (int k = 4; k < 7; k++) begin
      rq_addr = 8'(k);
      tick();
      chk("b2b_valid", rs_valid, 1'b1);
    end
    rq_valid = 1'b0;
    tick();
    chk("drain_valid", rs_valid, 1'b0);

    // clear_all with a read and strobe of ch3; out-of-range address.
    ev_valid = 8'b0000_1000;
    repeat (7) tick();
    clr = 1'b1;
    rd0(8'd3);
    chk("clr_preclear", rs_data, 32'd7);
    clr = 1'b0; ev_valid = '0;
    rd0(8'd3);
    chk("clr_after", rs_data, 32'd0);
    rd0(8'd8);
    chk("oob_err", rs_err, 1'b1);
    chk("oob_data", rs_data, 32'd0);

    // Randomized traffic on all instances.
    for (int k = 0; k < 600; k++) begin
      en         = ($urandom_range(0, 7) != 0);
      clr        = ($urandom_range(0, 40) == 0);
      ev_valid   = 8'($urandom);
      ev_inc     = 8'($urandom);
      rq_valid   = 1'($urandom_range(0, 1));
      rq_addr    = 8'($urandom_range(0, 9));
      rs_ready   = ($urandom_range(0, 3) != 0);
      n_ev_valid = 3'($urandom);
      n_ev_inc   = 24'($urandom);
      n_rq_valid = ($urandom_range(0, 2) == 0);
      n_rq_addr  = 2'($urandom);
      n_rs_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Asynchronous reset while a response is pending.
    idle();
    tick();
    ev_valid = 8'hFF; n_ev_valid = 3'b111; n_ev_inc = 24'h0A0A0A;
    repeat (3) tick();
    ev_valid = '0; n_ev_valid = '0;
    rs_ready = 1'b0; n_rs_ready = 1'b0; rq_valid = 1'b1; rq_addr = 8'd2; n_rq_valid = 1'b1;
    tick();
    chk("pre_rst_valid", rs_valid, 1'b1);
    rq_valid = 1'b0; n_rq_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", rs_valid, 1'b0);
    chk("async_rst_data", rs_data, 32'd0);
    chk("async_rst_valid_sat", s_valid, 1'b0);
    chk("async_rst_valid_wrap", w_valid, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    rs_ready = 1'b1; n_rs_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rd0(8'(c));
      chk("post_rst_zero", rs_data, 32'd0);
    end
    n_rq_valid = 1'b1; n_rq_addr = 2'd1;
    tick();
    n_rq_valid = 1'b0;
    chk("post_rst_zero_sat", s_data, 8'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
